// File: rtl/keypad_pkg.sv
// Shared types, constants and the {col,row} key map for the 4x4 matrix keypad.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HOLD     = 2'd2
   } scan_state_e;

   localparam logic [3:0] COL_INIT  = 4'b1000;
   localparam logic [3:0] KEY_CLEAR = 4'hE;
   localparam logic [3:0] KEY_ENTER = 4'hF;
   localparam logic [3:0] KEY_AUX   = 4'hD;

   // col bit3 = left column, row bit3 = top row; both expected one-hot.
   function automatic logic [3:0] key_map(input logic [3:0] col, input logic [3:0] row);
      logic [3:0] code;
      case ({col, row})
         8'b1000_1000: code = 4'h1;
         8'b1000_0100: code = 4'h2;
         8'b1000_0010: code = 4'h3;
         8'b1000_0001: code = 4'hA;
         8'b0100_1000: code = 4'h4;
         8'b0100_0100: code = 4'h5;
         8'b0100_0010: code = 4'h6;
         8'b0100_0001: code = 4'hB;
         8'b0010_1000: code = 4'h7;
         8'b0010_0100: code = 4'h8;
         8'b0010_0010: code = 4'h9;
         8'b0010_0001: code = 4'hC;
         8'b0001_1000: code = KEY_CLEAR;
         8'b0001_0100: code = 4'h0;
         8'b0001_0010: code = KEY_AUX;
         8'b0001_0001: code = KEY_ENTER;
         default:      code = 4'h0;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-clock pulse every DIV clocks.
module scan_tick_gen #(
   parameter int unsigned DIV = 450000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == LAST);

   always_comb begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad scan sequencer: column strobing, press/release debounce and a
// single-event valid/ack output per accepted key press.
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 450000,
   parameter int unsigned DEBOUNCE_TICKS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] filas,
   output logic [3:0] col,
   output logic       key_valid,
   output logic [3:0] key_code,
   input  logic       key_ack,
   output logic       key_down,
   output logic       overrun
);

   localparam int unsigned CW = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_TICKS - 1);

   logic              tick;
   logic [3:0]        rows_m_q, rows_s_q;
   scan_state_e       state_q, state_d;
   logic [3:0]        col_q, col_d, col_rot;
   logic [3:0]        cap_row_q, cap_row_d;
   logic [CW-1:0]     deb_cnt_q, deb_cnt_d;
   logic [CW-1:0]     rel_cnt_q, rel_cnt_d;
   logic              key_valid_q, key_valid_d;
   logic [3:0]        key_code_q, key_code_d;
   logic              key_down_q, key_down_d;
   logic              overrun_q, overrun_d;
   logic              post;

   scan_tick_gen #(
      .DIV(SCAN_DIV)
   ) u_tick (
      .clk  (clk),
      .reset(reset),
      .tick (tick)
   );

   assign col_rot = {col_q[0], col_q[3:1]};

   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      cap_row_d  = cap_row_q;
      deb_cnt_d  = deb_cnt_q;
      rel_cnt_d  = rel_cnt_q;
      key_down_d = key_down_q;
      post       = 1'b0;
      if (tick) begin
         case (state_q)
            SCAN: begin
               // Multi-row hits are ambiguous and treated as no key.
               if ($onehot(rows_s_q)) begin
                  cap_row_d = rows_s_q;
                  deb_cnt_d = CW'(1);
                  state_d   = DEBOUNCE;
               end else begin
                  col_d = col_rot;
               end
            end
            DEBOUNCE: begin
               if (rows_s_q == cap_row_q) begin
                  deb_cnt_d = deb_cnt_q + 1'b1;
                  if (deb_cnt_q == DEB_LAST) begin
                     post       = 1'b1;
                     key_down_d = 1'b1;
                     rel_cnt_d  = '0;
                     state_d    = HOLD;
                  end
               end else begin
                  col_d   = col_rot;
                  state_d = SCAN;
               end
            end
            HOLD: begin
               if (rows_s_q == 4'b0000) begin
                  rel_cnt_d = rel_cnt_q + 1'b1;
                  if (rel_cnt_q == DEB_LAST) begin
                     key_down_d = 1'b0;
                     col_d      = col_rot;
                     state_d    = SCAN;
                  end
               end else begin
                  rel_cnt_d = '0;
               end
            end
            default: state_d = SCAN;
         endcase
      end
   end

   // A new post wins over a same-cycle ack; overrun only when the old event was unacked.
   always_comb begin
      key_valid_d = key_valid_q;
      key_code_d  = key_code_q;
      overrun_d   = overrun_q;
      if (key_ack && key_valid_q) key_valid_d = 1'b0;
      if (post) begin
         key_valid_d = 1'b1;
         key_code_d  = key_map(col_q, cap_row_q);
         if (key_valid_q && !key_ack) overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rows_m_q    <= 4'b0000;
         rows_s_q    <= 4'b0000;
         state_q     <= SCAN;
         col_q       <= COL_INIT;
         cap_row_q   <= 4'b0000;
         deb_cnt_q   <= '0;
         rel_cnt_q   <= '0;
         key_valid_q <= 1'b0;
         key_code_q  <= 4'h0;
         key_down_q  <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         rows_m_q    <= filas;
         rows_s_q    <= rows_m_q;
         state_q     <= state_d;
         col_q       <= col_d;
         cap_row_q   <= cap_row_d;
         deb_cnt_q   <= deb_cnt_d;
         rel_cnt_q   <= rel_cnt_d;
         key_valid_q <= key_valid_d;
         key_code_q  <= key_code_d;
         key_down_q  <= key_down_d;
         overrun_q   <= overrun_d;
      end
   end

   assign col       = col_q;
   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;
   assign key_down  = key_down_q;
   assign overrun   = overrun_q;

endmodule
